mandel_pixel_sequencer: RTL

MANDEL_PIXEL_SEQUENCER -- requirements
Module: mandel_pixel_sequencer

---
 rtl/mandel_pixel_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mandel_pixel_sequencer.sv
// mandel_pixel_sequencer: walks the frame raster, feeds c to the engine
// and streams results. Optional watchdog: MANDEL_SEQ_WATCHDOG_EN.
module mandel_pixel_sequencer #(
  parameter int FIXED_POINT_WIDTH = 16,
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  parameter int MAX_ITER = 256,
  localparam int IW = $clog2(MAX_ITER),
  localparam int XW = $clog2(H_RES),
  localparam int YW = $clog2(V_RES)
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                frame_start,
  input  logic signed [FIXED_POINT_WIDTH-1:0] re_origin,
  input  logic signed [FIXED_POINT_WIDTH-1:0] im_origin,
  input  logic signed [FIXED_POINT_WIDTH-1:0] re_step,
  input  logic signed [FIXED_POINT_WIDTH-1:0] im_step,
  output logic                                eng_start,
  output logic signed [FIXED_POINT_WIDTH-1:0] eng_c_real,
  output logic signed [FIXED_POINT_WIDTH-1:0] eng_c_imag,
  input  logic                                eng_valid,
  input  logic                                eng_is_mandelbrot,
  input  logic [IW-1:0]                       eng_iterations,
  output logic                                pix_valid,
  input  logic                                pix_ready,
  output logic [XW-1:0]                       pix_x,
  output logic [YW-1:0]                       pix_y,
  output logic                                pix_in_set,
  output logic [IW-1:0]                       pix_iter,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                timeout
);

  localparam int W = FIXED_POINT_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
  localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER - 1);

  logic [2:0]          state;
  logic [2:0]          state_nx;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic signed [W-1:0] c_re;
  logic signed [W-1:0] c_im;
  logic signed [W-1:0] re_org;
  logic signed [W-1:0] re_stp;
  logic signed [W-1:0] im_stp;
  logic                accept;
  logic                last_px;
  logic                start_ok;
  logic                wd_fire;

  assign start_ok   = (state == S_IDLE) && frame_start;
  assign accept     = (state == S_OUT) && pix_ready;
  assign last_px    = (x == X_LAST) && (y == Y_LAST);
  assign eng_c_real = c_re;
  assign eng_c_imag = c_im;
  assign pix_x      = x;
  assign pix_y      = y;

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (frame_start) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_ARM;
      S_ARM:   state_nx = S_WAIT;
      S_WAIT:  if (eng_valid || wd_fire) state_nx = S_OUT;
      S_OUT:   if (pix_ready) state_nx = last_px ? S_IDLE : S_ISSUE;
      default: state_nx = S_IDLE;
    endcase
  end

  // state, registered strobes, raster position and coordinate accumulators
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      eng_start  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      x          <= '0;
      y          <= '0;
      c_re       <= '0;
      c_im       <= '0;
      re_org     <= '0;
      re_stp     <= '0;
      im_stp     <= '0;
      pix_in_set <= 1'b0;
      pix_iter   <= '0;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx != S_IDLE);
      eng_start  <= (state_nx == S_ISSUE);
      pix_valid  <= (state_nx == S_OUT);
      frame_done <= accept && last_px;
      if (start_ok) begin
        re_org <= re_origin;
        re_stp <= re_step;
        im_stp <= im_step;
        x      <= '0;
        y      <= '0;
        c_re   <= re_origin;
        c_im   <= im_origin;
      end
      if ((state == S_WAIT) && eng_valid) begin
        pix_in_set <= eng_is_mandelbrot;
        pix_iter   <= eng_iterations;
      end else if (wd_fire) begin
        pix_in_set <= 1'b1;
        pix_iter   <= ITER_MAX;
      end
      if (accept) begin
        if (x != X_LAST) begin
          x    <= x + 1'b1;
          c_re <= c_re + re_stp;
        end else begin
          x    <= '0;
          c_re <= re_org;
          y    <= y + 1'b1;
          c_im <= c_im + im_stp;
        end
      end
    end
  end

`ifdef MANDEL_SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(MAX_ITER + 4);
  localparam logic [WDW-1:0] WD_LAST = WDW'(MAX_ITER + 3);

  logic [WDW-1:0] wd_cnt;

  assign wd_fire = (state == S_WAIT) && !eng_valid && (wd_cnt == WD_LAST);

  // counts cycles spent in WAIT for the current pixel
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wd_cnt <= '0;
    end else if (state != S_WAIT) begin
      wd_cnt <= '0;
    end else if (!wd_fire) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // sticky abort flag, cleared when a new frame is accepted
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      timeout <= 1'b0;
    end else if (start_ok) begin
      timeout <= 1'b0;
    end else if (wd_fire) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
